// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add multiplier, unsigned or two's complement
// Optional macro MUL_SEQ_ZERO_BYPASS_EN: zero operands skip the shift-add loop.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [5:0]       LAST = 6'(WIDTH-1);

  logic [1:0]         state;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   upper;
  logic [WIDTH-1:0]   lower;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               zero_op;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude, so no extra bit is needed.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? (~a + ONE) : a;
    b_mag = (is_signed && b[WIDTH-1]) ? (~b + ONE) : b;
    sum   = {1'b0, upper} + (lower[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod  = {upper, lower};
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    zero_op = (a == '0) || (b == '0);
`else
    zero_op = 1'b0;
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      upper <= '0;
      lower <= '0;
      neg   <= 1'b0;
      c     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            // lower holds the multiplier and is shifted out as product bits arrive
            lower <= zero_op ? '0 : b_mag;
            upper <= '0;
            cnt   <= '0;
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            state <= zero_op ? FIN : CALC;
          end
        end
        CALC: begin
          {upper, lower} <= {sum, lower[WIDTH-1:1]};
          cnt            <= cnt + 6'd1;
          if (cnt == LAST) begin
            state <= FIN;
          end
        end
        FIN: begin
          c     <= neg ? (~prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed and random checks of mul_seq (WIDTH=8) against an arithmetic model
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] c;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_at = 0;
  logic [15:0] last_exp = '0;

  mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .c(c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[15:0];
  endfunction

  function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    if (x == 8'h00 || y == 8'h00) return 1;
`endif
    return 9;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an operation, scrambles inputs while busy, optionally re-pulses
  // start at E3, and checks latency, busy length, product and c stability.
  task automatic run_op(input string tag, input logic s, input logic [7:0] x,
                        input logic [7:0] y, input bit restart);
    int n;
    int busy_cnt;
    bit c_held;
    logic [15:0] exp_c;
    int exp_lat;
    exp_c = model(s, x, y);
    exp_lat = lat_of(x, y);
    is_signed = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; busy_cnt = 0; c_held = 1'b1;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (c !== last_exp) c_held = 1'b0;
      a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
      start = (restart && n == 2);
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    done_at = cyc;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy"}, busy_cnt, exp_lat);
    check({tag, "_c"}, c, exp_c);
    check({tag, "_c_hold"}, c_held, 1);
    last_exp = exp_c;
  endtask

  task automatic idle_check(input string tag, input int k);
    int pulses = 0;
    int busy_seen = 0;
    repeat (k) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    check({tag, "_extra_done"}, pulses, 0);
    check({tag, "_idle_busy"}, busy_seen, 0);
  endtask

  initial begin
    int first_done;
    logic [7:0] x, y;
    logic s;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_c", c, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("ff_x_ff", 1'b0, 8'hFF, 8'hFF, 1'b0);
    check("ff_x_ff_value", c, 16'hFE01);
    idle_check("ff_x_ff", 3);

    run_op("s80_x_s80", 1'b1, 8'h80, 8'h80, 1'b0);
    check("s80_x_s80_value", c, 16'h4000);
    idle_check("s80_x_s80", 2);

    run_op("m3_x_5", 1'b1, 8'hFD, 8'h05, 1'b0);
    check("m3_x_5_value", c, 16'hFFF1);
    idle_check("m3_x_5", 2);

    run_op("restart", 1'b0, 8'h12, 8'h34, 1'b1);
    idle_check("restart", 14);

    // reset mid-operation: abort at E4, c clears at once, no done follows
    is_signed = 1'b0; a = 8'h9A; b = 8'h77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_c", c, 0);
    check("abort_done", done, 0);
    last_exp = '0;
    #2;
    rst = 1'b0;
    idle_check("abort", 12);
    run_op("after_reset", 1'b0, 8'd7, 8'd6, 1'b0);
    check("after_reset_value", c, 16'h002A);

    // start in the done cycle
    run_op("b2b_first", 1'b1, 8'h81, 8'h7F, 1'b0);
    first_done = done_at;
    run_op("b2b_second", 1'b0, 8'hC3, 8'h0B, 1'b0);
    check("b2b_period", done_at - first_done, 10);
    idle_check("b2b", 2);

    run_op("zero_a", 1'b0, 8'h00, 8'h37, 1'b0);
    check("zero_a_value", c, 16'h0000);
    idle_check("zero_a", 2);

    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom);
      if (i % 8 == 3) x = 8'h00;
      if (i % 8 == 6) y = 8'h00;
      if (i % 8 == 5) begin x = 8'h80; y = 8'($urandom_range(0, 1) ? 8'h80 : 8'h7F); end
      run_op($sformatf("rand%0d", i), s, x, y, 1'b0);
      if (i % 3 == 0) idle_check($sformatf("rand%0d", i), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
